// File: rtl/wb_ddr_axi_bridge_pkg.sv
// Shared types and constants for the Wishbone-to-AXI4 DDR bridge.
// Widths, fixed AXI encodings and the bridge FSM state type live here.
package wb_ddr_axi_bridge_pkg;

    localparam int ID_W   = 4;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int SEL_W  = DATA_W / 8;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [2:0] SIZE_4B       = 3'b010;
    localparam logic [1:0] RESP_OKAY     = 2'b00;
    localparam logic [3:0] CACHE_DEFAULT = 4'b0011;

    typedef enum logic [2:0] {
        IDLE,
        WR_REQ,
        WR_RESP,
        RD_REQ,
        RD_RESP,
        DONE
    } state_t;

endpackage

// File: rtl/wb_ddr_axi_bridge_if.sv
// Bundle of the Wishbone slave port and the single-ID AXI4 DDR port.
// The master modport is the bridge view (AXI master); slave is the environment view.
interface wb_ddr_axi_bridge_if;
    import wb_ddr_axi_bridge_pkg::*;

    logic [ADDR_W-1:0] wb_adr_i;
    logic [DATA_W-1:0] wb_dat_i;
    logic [SEL_W-1:0]  wb_sel_i;
    logic              wb_we_i;
    logic              wb_cyc_i;
    logic              wb_stb_i;
    logic [DATA_W-1:0] wb_dat_o;
    logic              wb_ack_o;
    logic              wb_err_o;

    logic [ID_W-1:0]   ddr_awid;
    logic [ADDR_W-1:0] ddr_awaddr;
    logic [7:0]        ddr_awlen;
    logic [2:0]        ddr_awsize;
    logic [1:0]        ddr_awburst;
    logic              ddr_awlock;
    logic [3:0]        ddr_awcache;
    logic [2:0]        ddr_awprot;
    logic [3:0]        ddr_awqos;
    logic              ddr_awvalid;
    logic              ddr_awready;

    logic [DATA_W-1:0] ddr_wdata;
    logic [SEL_W-1:0]  ddr_wstrb;
    logic              ddr_wlast;
    logic              ddr_wvalid;
    logic              ddr_wready;

    logic [ID_W-1:0]   ddr_bid;
    logic [1:0]        ddr_bresp;
    logic              ddr_bvalid;
    logic              ddr_bready;

    logic [ID_W-1:0]   ddr_arid;
    logic [ADDR_W-1:0] ddr_araddr;
    logic [7:0]        ddr_arlen;
    logic [2:0]        ddr_arsize;
    logic [1:0]        ddr_arburst;
    logic              ddr_arlock;
    logic [3:0]        ddr_arcache;
    logic [2:0]        ddr_arprot;
    logic [3:0]        ddr_arqos;
    logic              ddr_arvalid;
    logic              ddr_arready;

    logic [ID_W-1:0]   ddr_rid;
    logic [DATA_W-1:0] ddr_rdata;
    logic [1:0]        ddr_rresp;
    logic              ddr_rlast;
    logic              ddr_rvalid;
    logic              ddr_rready;

    modport master (
        input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        output wb_dat_o, wb_ack_o, wb_err_o,
        output ddr_awid, ddr_awaddr, ddr_awlen, ddr_awsize, ddr_awburst,
        output ddr_awlock, ddr_awcache, ddr_awprot, ddr_awqos, ddr_awvalid,
        input  ddr_awready,
        output ddr_wdata, ddr_wstrb, ddr_wlast, ddr_wvalid,
        input  ddr_wready,
        input  ddr_bid, ddr_bresp, ddr_bvalid,
        output ddr_bready,
        output ddr_arid, ddr_araddr, ddr_arlen, ddr_arsize, ddr_arburst,
        output ddr_arlock, ddr_arcache, ddr_arprot, ddr_arqos, ddr_arvalid,
        input  ddr_arready,
        input  ddr_rid, ddr_rdata, ddr_rresp, ddr_rlast, ddr_rvalid,
        output ddr_rready
    );

    modport slave (
        output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_cyc_i, wb_stb_i,
        input  wb_dat_o, wb_ack_o, wb_err_o,
        input  ddr_awid, ddr_awaddr, ddr_awlen, ddr_awsize, ddr_awburst,
        input  ddr_awlock, ddr_awcache, ddr_awprot, ddr_awqos, ddr_awvalid,
        output ddr_awready,
        input  ddr_wdata, ddr_wstrb, ddr_wlast, ddr_wvalid,
        output ddr_wready,
        output ddr_bid, ddr_bresp, ddr_bvalid,
        input  ddr_bready,
        input  ddr_arid, ddr_araddr, ddr_arlen, ddr_arsize, ddr_arburst,
        input  ddr_arlock, ddr_arcache, ddr_arprot, ddr_arqos, ddr_arvalid,
        output ddr_arready,
        output ddr_rid, ddr_rdata, ddr_rresp, ddr_rlast, ddr_rvalid,
        input  ddr_rready
    );

endinterface

// File: rtl/wb_ddr_axi_bridge.sv
// Wishbone B3 classic slave to AXI4 master: each Wishbone access becomes one
// single-beat AXI write or read; AXI errors and out-of-range addresses give wb_err_o.
module wb_ddr_axi_bridge
    import wb_ddr_axi_bridge_pkg::*;
#(
    parameter logic [ID_W-1:0]   AXI_ID   = 4'h0,
    parameter logic [ADDR_W-1:0] MEM_SIZE = 32'h2000_0000
) (
    input  logic                clk,
    input  logic                rst,
    wb_ddr_axi_bridge_if.master bus
);

    state_t            state;
    state_t            next_state;

    logic [ADDR_W-1:0] adr_q;
    logic [DATA_W-1:0] dat_q;
    logic [SEL_W-1:0]  sel_q;
    logic [DATA_W-1:0] rdata_q;
    logic              aw_done;
    logic              w_done;
    logic              err_q;
    logic              abort_q;

    logic              req;
    logic              out_of_range;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;
    logic              ar_hs;
    logic              r_hs;
    logic              b_err;
    logic              r_err;
    logic              aw_all;
    logic              w_all;

    assign req          = bus.wb_cyc_i & bus.wb_stb_i;
    assign out_of_range = (bus.wb_adr_i >= MEM_SIZE);

    assign aw_hs = (state == WR_REQ) & ~aw_done & bus.ddr_awready;
    assign w_hs  = (state == WR_REQ) & ~w_done  & bus.ddr_wready;
    assign b_hs  = (state == WR_RESP) & bus.ddr_bvalid;
    assign ar_hs = (state == RD_REQ)  & bus.ddr_arready;
    assign r_hs  = (state == RD_RESP) & bus.ddr_rvalid;

    // A handshake in the current cycle counts as done, so both channels may finish together.
    assign aw_all = aw_done | aw_hs;
    assign w_all  = w_done  | w_hs;

    assign b_err = (bus.ddr_bresp != RESP_OKAY) | (bus.ddr_bid != AXI_ID);
    assign r_err = (bus.ddr_rresp != RESP_OKAY) | (bus.ddr_rid != AXI_ID) | ~bus.ddr_rlast;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    if (out_of_range) begin
                        next_state = DONE;
                    end else if (bus.wb_we_i) begin
                        next_state = WR_REQ;
                    end else begin
                        next_state = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                if (aw_all && w_all) begin
                    next_state = WR_RESP;
                end
            end
            WR_RESP: begin
                if (b_hs) begin
                    next_state = DONE;
                end
            end
            RD_REQ: begin
                if (ar_hs) begin
                    next_state = RD_RESP;
                end
            end
            RD_RESP: begin
                if (r_hs) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // DONE is always followed by IDLE, so a strobe still high during ack cannot re-issue.
    always_comb begin
        bus.ddr_awvalid = 1'b0;
        bus.ddr_wvalid  = 1'b0;
        bus.ddr_bready  = 1'b0;
        bus.ddr_arvalid = 1'b0;
        bus.ddr_rready  = 1'b0;
        bus.wb_ack_o    = 1'b0;
        bus.wb_err_o    = 1'b0;
        case (state)
            WR_REQ: begin
                bus.ddr_awvalid = ~aw_done;
                bus.ddr_wvalid  = ~w_done;
            end
            WR_RESP: begin
                bus.ddr_bready = 1'b1;
            end
            RD_REQ: begin
                bus.ddr_arvalid = 1'b1;
            end
            RD_RESP: begin
                bus.ddr_rready = 1'b1;
            end
            DONE: begin
                if (!abort_q && bus.wb_cyc_i) begin
                    bus.wb_ack_o = ~err_q;
                    bus.wb_err_o = err_q;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            adr_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
            rdata_q <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    aw_done <= 1'b0;
                    w_done  <= 1'b0;
                    abort_q <= 1'b0;
                    if (req) begin
                        adr_q <= {bus.wb_adr_i[ADDR_W-1:2], 2'b00};
                        dat_q <= bus.wb_dat_i;
                        sel_q <= bus.wb_sel_i;
                        err_q <= out_of_range;
                    end
                end
                WR_REQ: begin
                    if (aw_hs) begin
                        aw_done <= 1'b1;
                    end
                    if (w_hs) begin
                        w_done <= 1'b1;
                    end
                    if (!bus.wb_cyc_i) begin
                        abort_q <= 1'b1;
                    end
                end
                WR_RESP: begin
                    if (b_hs) begin
                        err_q <= b_err;
                    end
                    if (!bus.wb_cyc_i) begin
                        abort_q <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (!bus.wb_cyc_i) begin
                        abort_q <= 1'b1;
                    end
                end
                RD_RESP: begin
                    // Data of an abandoned read never reaches wb_dat_o.
                    if (r_hs) begin
                        err_q <= r_err;
                        if (!abort_q && bus.wb_cyc_i) begin
                            rdata_q <= bus.ddr_rdata;
                        end
                    end
                    if (!bus.wb_cyc_i) begin
                        abort_q <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.wb_dat_o = rdata_q;

    assign bus.ddr_awid    = AXI_ID;
    assign bus.ddr_awaddr  = adr_q;
    assign bus.ddr_awlen   = 8'd0;
    assign bus.ddr_awsize  = SIZE_4B;
    assign bus.ddr_awburst = BURST_INCR;
    assign bus.ddr_awlock  = 1'b0;
    assign bus.ddr_awcache = CACHE_DEFAULT;
    assign bus.ddr_awprot  = 3'd0;
    assign bus.ddr_awqos   = 4'd0;

    assign bus.ddr_wdata = dat_q;
    assign bus.ddr_wstrb = sel_q;
    assign bus.ddr_wlast = 1'b1;

    assign bus.ddr_arid    = AXI_ID;
    assign bus.ddr_araddr  = adr_q;
    assign bus.ddr_arlen   = 8'd0;
    assign bus.ddr_arsize  = SIZE_4B;
    assign bus.ddr_arburst = BURST_INCR;
    assign bus.ddr_arlock  = 1'b0;
    assign bus.ddr_arcache = CACHE_DEFAULT;
    assign bus.ddr_arprot  = 3'd0;
    assign bus.ddr_arqos   = 4'd0;

endmodule
